multicycle_control_fsm: RTL and testbench

- Main control sequencer for a multi-cycle variant of the RV32I datapath.
- Steps each instruction through fetch/decode/execute/memory/writeback over several cycles, reusing one ALU and one unified memory.
- Drives the datapath mux selects, write enables, and ImmSrc for the immediate generator (00 I, 01 S, 10 B, 11 J).
- Adds a memory wait-state handshake and a retired-instruction counter.

---
 rtl/multicycle_control_fsm.sv | 196 +++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Main control sequencer for a multi-cycle RV32I datapath.
// Walks each instruction through fetch/decode/execute/memory/writeback,
// drives the datapath selects and write enables, handshakes with memory
// through mem_ready and counts retired instructions.
module multicycle_control_fsm #(
    parameter int COUNT_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         op,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               AdrSrc,
    output logic               MemWrite,
    output logic               mem_req,
    output logic               IRWrite,
    output logic [1:0]         ResultSrc,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUOp,
    output logic [1:0]         ImmSrc,
    output logic               RegWrite,
    output logic               illegal,
    output logic [3:0]         state,
    output logic [COUNT_W-1:0] instr_count
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_ALUWB    = 4'd7;
    localparam logic [3:0] S_EXECI    = 4'd8;
    localparam logic [3:0] S_JAL      = 4'd9;
    localparam logic [3:0] S_BEQ      = 4'd10;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    logic [3:0]         state_q;
    logic [3:0]         state_d;
    logic [COUNT_W-1:0] instr_count_q;
    logic [COUNT_W-1:0] instr_count_d;
    logic               retire;
    logic [3:0]         dec_state;

    // State register and retired-instruction counter; reset aborts any instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_FETCH;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            instr_count_q <= instr_count_d;
        end
    end

    // Next-state logic; unused encodings fall back to FETCH.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_BEQ:      state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    // An instruction retires when one of its final states hands back to FETCH.
    always_comb begin
        retire = 1'b0;
        if (state_d == S_FETCH) begin
            case (state_q)
                S_MEMWB, S_MEMWRITE, S_ALUWB, S_BEQ: retire = 1'b1;
                default:                             retire = 1'b0;
            endcase
        end
        instr_count_d = retire ? (instr_count_q + COUNT_W'(1)) : instr_count_q;
    end

    // Output decode; while reset is held the FETCH selects are shown with all enables off.
    always_comb begin
        PCWrite   = 1'b0;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        mem_req   = 1'b0;
        IRWrite   = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ALUOp     = 2'b00;
        ImmSrc    = 2'b00;
        RegWrite  = 1'b0;
        illegal   = 1'b0;
        dec_state = reset ? S_FETCH : state_q;
        case (dec_state)
            S_FETCH: begin
                mem_req   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                ImmSrc  = 2'b10;
                case (op)
                    OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL: illegal = 1'b0;
                    default:                                  illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ImmSrc  = (op == OP_SW) ? 2'b01 : 2'b00;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req  = 1'b1;
                MemWrite = 1'b1;
                AdrSrc   = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b01;
                PCWrite = zero;
            end
            S_JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                ImmSrc  = 2'b11;
                PCWrite = 1'b1;
            end
            default: begin
                PCWrite = 1'b0;
            end
        endcase
        if (reset) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
            mem_req  = 1'b0;
            illegal  = 1'b0;
        end
    end

    assign state       = state_q;
    assign instr_count = instr_count_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Testbench for multicycle_control_fsm: a per-cycle vector table for the
// instruction mix and reset abort, plus a hand-written counter wrap run
// on a narrow-counter instance.
module tb_multicycle_control_fsm;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BAD = 7'b1110011;

    // Control word: {PCWrite,AdrSrc,MemWrite,mem_req,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUOp,ImmSrc,RegWrite,illegal}
    localparam logic [16:0] C_RST    = 17'b0_0_0_0_0_10_00_10_00_00_0_0;
    localparam logic [16:0] C_F_RDY  = 17'b1_0_0_1_1_10_00_10_00_00_0_0;
    localparam logic [16:0] C_F_WAIT = 17'b0_0_0_1_0_10_00_10_00_00_0_0;
    localparam logic [16:0] C_DEC    = 17'b0_0_0_0_0_00_01_01_00_10_0_0;
    localparam logic [16:0] C_DEC_IL = 17'b0_0_0_0_0_00_01_01_00_10_0_1;
    localparam logic [16:0] C_MA_LW  = 17'b0_0_0_0_0_00_10_01_00_00_0_0;
    localparam logic [16:0] C_MA_SW  = 17'b0_0_0_0_0_00_10_01_00_01_0_0;
    localparam logic [16:0] C_MR     = 17'b0_1_0_1_0_00_00_00_00_00_0_0;
    localparam logic [16:0] C_MWB    = 17'b0_0_0_0_0_01_00_00_00_00_1_0;
    localparam logic [16:0] C_MW     = 17'b0_1_1_1_0_00_00_00_00_00_0_0;
    localparam logic [16:0] C_EXR    = 17'b0_0_0_0_0_00_10_00_10_00_0_0;
    localparam logic [16:0] C_EXI    = 17'b0_0_0_0_0_00_10_01_10_00_0_0;
    localparam logic [16:0] C_AWB    = 17'b0_0_0_0_0_00_00_00_00_00_1_0;
    localparam logic [16:0] C_BEQ_T  = 17'b1_0_0_0_0_00_10_00_01_00_0_0;
    localparam logic [16:0] C_BEQ_N  = 17'b0_0_0_0_0_00_10_00_01_00_0_0;
    localparam logic [16:0] C_JAL    = 17'b1_0_0_0_0_00_01_10_00_11_0_0;

    typedef struct {
        logic        rst;
        logic [6:0]  op;
        logic        zero;
        logic        rdy;
        logic [3:0]  st;
        logic [16:0] ctrl;
        logic [31:0] cnt;
    } vec_t;

    typedef struct {
        int          row;
        logic [3:0]  st;
        logic [16:0] ctrl;
        logic [31:0] cnt;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [6:0] op = 7'd0;
    logic zero = 1'b0;
    logic mem_ready = 1'b0;
    logic PCWrite, AdrSrc, MemWrite, mem_req, IRWrite, RegWrite, illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
    logic [3:0] state;
    logic [31:0] instr_count;

    logic r4 = 1'b1;
    logic [6:0] op4 = 7'd0;
    logic p4_pcw, p4_adr, p4_mw, p4_req, p4_irw, p4_rw, p4_ill;
    logic [1:0] p4_rs, p4_a, p4_b, p4_aluop, p4_imm;
    logic [3:0] st4;
    logic [3:0] cnt4;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    multicycle_control_fsm #(.COUNT_W(32)) dut (
        .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .mem_req(mem_req),
        .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .ImmSrc(ImmSrc), .RegWrite(RegWrite), .illegal(illegal),
        .state(state), .instr_count(instr_count)
    );

    multicycle_control_fsm #(.COUNT_W(4)) dut4 (
        .clk(clk), .reset(r4), .op(op4), .zero(1'b0), .mem_ready(1'b1),
        .PCWrite(p4_pcw), .AdrSrc(p4_adr), .MemWrite(p4_mw), .mem_req(p4_req),
        .IRWrite(p4_irw), .ResultSrc(p4_rs), .ALUSrcA(p4_a), .ALUSrcB(p4_b),
        .ALUOp(p4_aluop), .ImmSrc(p4_imm), .RegWrite(p4_rw), .illegal(p4_ill),
        .state(st4), .instr_count(cnt4)
    );

    wire [16:0] act_ctrl = {PCWrite, AdrSrc, MemWrite, mem_req, IRWrite, ResultSrc,
                            ALUSrcA, ALUSrcB, ALUOp, ImmSrc, RegWrite, illegal};

    task automatic add(input logic r, input logic [6:0] o, input logic z, input logic rd,
                       input logic [3:0] s, input logic [16:0] c, input logic [31:0] n);
        vec_t v;
        v.rst = r; v.op = o; v.zero = z; v.rdy = rd; v.st = s; v.ctrl = c; v.cnt = n;
        tbl.push_back(v);
    endtask

    initial begin
        exp_t e;
        // reset held
        add(1, 7'd0,   0, 0, 4'd0,  C_RST,    0);
        add(1, 7'd0,   0, 0, 4'd0,  C_RST,    0);
        // lw, no wait states: 0,1,2,3,4
        add(0, OP_LW,  0, 1, 4'd0,  C_F_RDY,  0);
        add(0, OP_LW,  0, 1, 4'd1,  C_DEC,    0);
        add(0, OP_LW,  0, 1, 4'd2,  C_MA_LW,  0);
        add(0, OP_LW,  0, 1, 4'd3,  C_MR,     0);
        add(0, OP_LW,  0, 1, 4'd4,  C_MWB,    0);
        // sw with three wait states in MEMWRITE
        add(0, OP_SW,  0, 1, 4'd0,  C_F_RDY,  1);
        add(0, OP_SW,  0, 1, 4'd1,  C_DEC,    1);
        add(0, OP_SW,  0, 1, 4'd2,  C_MA_SW,  1);
        add(0, OP_SW,  0, 0, 4'd5,  C_MW,     1);
        add(0, OP_SW,  0, 0, 4'd5,  C_MW,     1);
        add(0, OP_SW,  0, 0, 4'd5,  C_MW,     1);
        add(0, OP_SW,  0, 1, 4'd5,  C_MW,     1);
        // beq taken, then not taken
        add(0, OP_BEQ, 1, 1, 4'd0,  C_F_RDY,  2);
        add(0, OP_BEQ, 1, 1, 4'd1,  C_DEC,    2);
        add(0, OP_BEQ, 1, 1, 4'd10, C_BEQ_T,  2);
        add(0, OP_BEQ, 0, 1, 4'd0,  C_F_RDY,  3);
        add(0, OP_BEQ, 0, 1, 4'd1,  C_DEC,    3);
        add(0, OP_BEQ, 0, 1, 4'd10, C_BEQ_N,  3);
        // jal
        add(0, OP_JAL, 0, 1, 4'd0,  C_F_RDY,  4);
        add(0, OP_JAL, 0, 1, 4'd1,  C_DEC,    4);
        add(0, OP_JAL, 0, 1, 4'd9,  C_JAL,    4);
        add(0, OP_JAL, 0, 1, 4'd7,  C_AWB,    4);
        // unsupported opcode
        add(0, OP_BAD, 0, 1, 4'd0,  C_F_RDY,  5);
        add(0, OP_BAD, 0, 1, 4'd1,  C_DEC_IL, 5);
        // R-type with one fetch wait state
        add(0, OP_R,   0, 0, 4'd0,  C_F_WAIT, 5);
        add(0, OP_R,   0, 1, 4'd0,  C_F_RDY,  5);
        add(0, OP_R,   0, 1, 4'd1,  C_DEC,    5);
        add(0, OP_R,   0, 1, 4'd6,  C_EXR,    5);
        add(0, OP_R,   0, 1, 4'd7,  C_AWB,    5);
        // I-type
        add(0, OP_I,   0, 1, 4'd0,  C_F_RDY,  6);
        add(0, OP_I,   0, 1, 4'd1,  C_DEC,    6);
        add(0, OP_I,   0, 1, 4'd8,  C_EXI,    6);
        add(0, OP_I,   0, 1, 4'd7,  C_AWB,    6);
        // lw aborted by reset while waiting in MEMREAD
        add(0, OP_LW,  0, 1, 4'd0,  C_F_RDY,  7);
        add(0, OP_LW,  0, 1, 4'd1,  C_DEC,    7);
        add(0, OP_LW,  0, 1, 4'd2,  C_MA_LW,  7);
        add(0, OP_LW,  0, 0, 4'd3,  C_MR,     7);
        add(1, OP_LW,  0, 0, 4'd3,  C_RST,    7);
        add(1, OP_LW,  0, 1, 4'd0,  C_RST,    0);
        add(0, OP_LW,  0, 1, 4'd0,  C_F_RDY,  0);

        foreach (tbl[i]) begin
            @(posedge clk);
            #1;
            reset = tbl[i].rst; op = tbl[i].op; zero = tbl[i].zero; mem_ready = tbl[i].rdy;
            sb.push_back('{row: i, st: tbl[i].st, ctrl: tbl[i].ctrl, cnt: tbl[i].cnt});
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if (state !== e.st) begin
                n_fail++;
                $display("FAIL state row %0d: got %0d, want %0d", e.row, state, e.st);
            end
            n_checks++;
            if (act_ctrl !== e.ctrl) begin
                n_fail++;
                $display("FAIL ctrl row %0d: got %b, want %b", e.row, act_ctrl, e.ctrl);
            end
            n_checks++;
            if (instr_count !== e.cnt) begin
                n_fail++;
                $display("FAIL count row %0d: got %0d, want %0d", e.row, instr_count, e.cnt);
            end
            $display("row %0d: state=%0d ctrl=%b count=%0d", e.row, state, act_ctrl, instr_count);
        end

        // counter wrap on the 4-bit instance: 16 R-type instructions of 4 cycles each
        @(posedge clk);
        #1;
        r4 = 1'b0;
        op4 = OP_R;
        for (int k = 0; k < 16; k++) begin
            repeat (4) @(posedge clk);
            #1;
            sb.push_back('{row: k, st: 4'd0, ctrl: 17'd0, cnt: 32'((k + 1) % 16)});
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if (st4 !== e.st || {28'd0, cnt4} !== e.cnt) begin
                n_fail++;
                $display("FAIL wrap instr %0d: state=%0d count=%0d, want state=%0d count=%0d",
                         e.row, st4, cnt4, e.st, e.cnt);
            end
            $display("wrap instr %0d: state=%0d count=%0d", e.row, st4, cnt4);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
